// File: rtl/fuzz_pkg.sv
// Shared types and constants for the sequential type-2 fuzzifier: FSM states,
// trapezoid indices, region classification and divider sizing.
package fuzz_pkg;

  localparam int N_TRAP    = 6;
  localparam int DIV_NUM_W = 16;
  localparam int DIV_DEN_W = 8;
  localparam int DIV_CNT_W = $clog2(DIV_NUM_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DIV  = 2'd2,
    S_FIM  = 2'd3
  } estado_t;

  localparam logic [2:0] T_MF01_UP  = 3'd0;
  localparam logic [2:0] T_MF01_LOW = 3'd1;
  localparam logic [2:0] T_MF02_UP  = 3'd2;
  localparam logic [2:0] T_MF02_LOW = 3'd3;
  localparam logic [2:0] T_MF03_UP  = 3'd4;
  localparam logic [2:0] T_MF03_LOW = 3'd5;

  typedef enum logic [2:0] {
    R_BAIXO   = 3'd0,
    R_SUBIDA  = 3'd1,
    R_TOPO    = 3'd2,
    R_DESCIDA = 3'd3,
    R_ALTO    = 3'd4
  } regiao_t;

  // The top region wins ties at C, so x == C == D still yields full membership.
  function automatic regiao_t classifica(input logic [7:0] x, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d);
    regiao_t r;
    if (x <= a)      r = R_BAIXO;
    else if (x < b)  r = R_SUBIDA;
    else if (x <= c) r = R_TOPO;
    else if (x < d)  r = R_DESCIDA;
    else             r = R_ALTO;
    return r;
  endfunction

endpackage

// File: rtl/fuzz_divisor.sv
// 16/8 restoring serial divider: the first quotient bit is resolved on the
// start edge, so feito is high during the 16th cycle after inicio.
module fuzz_divisor
  import fuzz_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [DIV_NUM_W-1:0] numerador,
  input  logic [DIV_DEN_W-1:0] denominador,
  output logic [DIV_NUM_W-1:0] quociente,
  output logic                 feito
);

  localparam logic [DIV_CNT_W-1:0] PASSOS = DIV_CNT_W'(DIV_NUM_W);

  logic [DIV_DEN_W-1:0] resto_r, den_r;
  logic [DIV_NUM_W-1:0] quo_r;
  logic [DIV_CNT_W-1:0] cont_r;
  logic                 ocupado_r;

  logic [DIV_DEN_W-1:0] resto_in, resto_out, den_in;
  logic [DIV_NUM_W-1:0] quo_in, quo_out;
  logic [DIV_DEN_W:0]   desloc;

  // quo_r doubles as the numerator shift register; quotient bits enter at the LSB.
  always_comb begin
    resto_in = inicio ? '0 : resto_r;
    quo_in   = inicio ? numerador : quo_r;
    den_in   = inicio ? denominador : den_r;
    desloc   = {resto_in, quo_in[DIV_NUM_W-1]};
    if (desloc >= {1'b0, den_in}) begin
      resto_out = DIV_DEN_W'(desloc - {1'b0, den_in});
      quo_out   = {quo_in[DIV_NUM_W-2:0], 1'b1};
    end else begin
      resto_out = desloc[DIV_DEN_W-1:0];
      quo_out   = {quo_in[DIV_NUM_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resto_r   <= '0;
      den_r     <= '0;
      quo_r     <= '0;
      cont_r    <= '0;
      ocupado_r <= 1'b0;
    end else if (inicio) begin
      resto_r   <= resto_out;
      quo_r     <= quo_out;
      den_r     <= den_in;
      cont_r    <= DIV_CNT_W'(1);
      ocupado_r <= 1'b1;
    end else if (ocupado_r) begin
      if (cont_r == PASSOS) begin
        ocupado_r <= 1'b0;
      end else begin
        resto_r <= resto_out;
        quo_r   <= quo_out;
        cont_r  <= cont_r + 1'b1;
      end
    end
  end

  assign quociente = quo_r;
  assign feito     = ocupado_r && (cont_r == PASSOS);

endmodule

// File: rtl/fuzz_sequenciador.sv
// Sequential interval type-2 fuzzifier: evaluates six trapezoids one at a time
// through a shared serial divider and publishes all degrees atomically.
module fuzz_sequenciador
  import fuzz_pkg::*;
#(
  parameter logic [47:0] P_A = 48'h96_8C_46_3C_0A_00,
  parameter logic [47:0] P_B = 48'hBE_B4_6E_64_1E_14,
  parameter logic [47:0] P_C = 48'hFF_FF_82_8C_32_3C,
  parameter logic [47:0] P_D = 48'hFF_FF_AA_B4_5A_64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] entrada,
  input  logic       valido,
  output logic       pronto,
  output logic       fim,
  output logic [7:0] MF_01_UP,
  output logic [7:0] MF_01_LOW,
  output logic [7:0] MF_02_UP,
  output logic [7:0] MF_02_LOW,
  output logic [7:0] MF_03_UP,
  output logic [7:0] MF_03_LOW,
  output logic       Ativo_1,
  output logic       Ativo_2,
  output logic       Ativo_3,
  output estado_t    estado
);

  // Handshake: a sample is taken on an edge where valido && pronto; pronto is
  // high only in IDLE, and valido in any other state is dropped, not queued.

  localparam logic [2:0] IDX_ULTIMO = 3'(N_TRAP - 1);

  estado_t    estado_r, estado_n;
  logic [7:0] x_r;
  logic [2:0] idx_r;
  logic [7:0] sombra [N_TRAP];

  logic [7:0]           ca, cb, cc, cd, dif;
  regiao_t              regiao;
  logic [DIV_NUM_W-1:0] num, quociente;
  logic [DIV_DEN_W-1:0] den;
  logic                 div_inicio, div_feito;
  logic                 aceita, grava, avanca;
  logic [7:0]           grava_val;

  assign ca     = P_A[{idx_r, 3'b000} +: 8];
  assign cb     = P_B[{idx_r, 3'b000} +: 8];
  assign cc     = P_C[{idx_r, 3'b000} +: 8];
  assign cd     = P_D[{idx_r, 3'b000} +: 8];
  assign regiao = classifica(x_r, ca, cb, cc, cd);

  // 255*dif as (dif<<8)-dif; dif is strictly below den, keeping the quotient < 255.
  assign dif = (regiao == R_SUBIDA) ? (x_r - ca) : (cd - x_r);
  assign den = (regiao == R_SUBIDA) ? (cb - ca) : (cd - cc);
  assign num = {dif, 8'h00} - {8'h00, dif};

  fuzz_divisor u_divisor (
    .clk        (clk),
    .rst        (rst),
    .inicio     (div_inicio),
    .numerador  (num),
    .denominador(den),
    .quociente  (quociente),
    .feito      (div_feito)
  );

  always_comb begin
    estado_n   = estado_r;
    aceita     = 1'b0;
    div_inicio = 1'b0;
    grava      = 1'b0;
    grava_val  = '0;
    avanca     = 1'b0;
    case (estado_r)
      S_IDLE: begin
        if (valido) begin
          aceita   = 1'b1;
          estado_n = S_EVAL;
        end
      end
      S_EVAL: begin
        case (regiao)
          R_SUBIDA, R_DESCIDA: begin
            div_inicio = 1'b1;
            estado_n   = S_DIV;
          end
          R_TOPO: begin
            grava     = 1'b1;
            grava_val = 8'hFF;
            avanca    = 1'b1;
          end
          default: begin
            grava  = 1'b1;
            avanca = 1'b1;
          end
        endcase
      end
      S_DIV: begin
        if (div_feito) begin
          // Saturation only matters for a zero denominator (all-ones quotient).
          grava     = 1'b1;
          grava_val = (quociente[15:8] != 8'h00) ? 8'hFF : quociente[7:0];
          avanca    = 1'b1;
        end
      end
      S_FIM:   estado_n = S_IDLE;
      default: estado_n = S_IDLE;
    endcase
    if (avanca) estado_n = (idx_r == IDX_ULTIMO) ? S_FIM : S_EVAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_r  <= S_IDLE;
      x_r       <= '0;
      idx_r     <= '0;
      fim       <= 1'b0;
      MF_01_UP  <= '0;
      MF_01_LOW <= '0;
      MF_02_UP  <= '0;
      MF_02_LOW <= '0;
      MF_03_UP  <= '0;
      MF_03_LOW <= '0;
      Ativo_1   <= 1'b0;
      Ativo_2   <= 1'b0;
      Ativo_3   <= 1'b0;
      for (int i = 0; i < N_TRAP; i++) sombra[i] <= '0;
    end else begin
      estado_r <= estado_n;
      fim      <= (estado_r == S_FIM);
      if (aceita) begin
        x_r   <= entrada;
        idx_r <= '0;
      end else if (avanca) begin
        idx_r <= idx_r + 1'b1;
      end
      if (grava) sombra[idx_r] <= grava_val;
      if (estado_r == S_FIM) begin
        MF_01_UP  <= sombra[T_MF01_UP];
        MF_01_LOW <= sombra[T_MF01_LOW];
        MF_02_UP  <= sombra[T_MF02_UP];
        MF_02_LOW <= sombra[T_MF02_LOW];
        MF_03_UP  <= sombra[T_MF03_UP];
        MF_03_LOW <= sombra[T_MF03_LOW];
        Ativo_1   <= (sombra[T_MF01_UP] != 8'h00);
        Ativo_2   <= (sombra[T_MF02_UP] != 8'h00);
        Ativo_3   <= (sombra[T_MF03_UP] != 8'h00);
      end
    end
  end

  assign pronto = (estado_r == S_IDLE);
  assign estado = estado_r;

endmodule

// File: tb/tb_fuzz_sequenciador.sv
// Bench for fuzz_sequenciador: directed cases, reset abort, busy-input
// rejection and a randomized sweep against a trapezoid reference model.
module tb_fuzz_sequenciador;
  import fuzz_pkg::*;

  localparam int W = 51;

  logic       clk, rst, valido, pronto, fim;
  logic [7:0] entrada;
  logic [7:0] MF_01_UP, MF_01_LOW, MF_02_UP, MF_02_LOW, MF_03_UP, MF_03_LOW;
  logic       Ativo_1, Ativo_2, Ativo_3;
  estado_t    estado;

  logic [47:0] pa = 48'h96_8C_46_3C_0A_00;
  logic [47:0] pb = 48'hBE_B4_6E_64_1E_14;
  logic [47:0] pc = 48'hFF_FF_82_8C_32_3C;
  logic [47:0] pd = 48'hFF_FF_AA_B4_5A_64;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [W-1:0] last_pub;
  int n_checks, n_errors;
  int cyc, fim_count, acc_count, aborted;
  int last_acc_edge, last_fim_edge, last_lat;
  bit busy_m;

  fuzz_sequenciador dut (
    .clk(clk), .rst(rst), .entrada(entrada), .valido(valido),
    .pronto(pronto), .fim(fim),
    .MF_01_UP(MF_01_UP), .MF_01_LOW(MF_01_LOW),
    .MF_02_UP(MF_02_UP), .MF_02_LOW(MF_02_LOW),
    .MF_03_UP(MF_03_UP), .MF_03_LOW(MF_03_LOW),
    .Ativo_1(Ativo_1), .Ativo_2(Ativo_2), .Ativo_3(Ativo_3),
    .estado(estado)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Reference: piecewise-linear trapezoid with integer truncation.
  function automatic int grau(input int x, input int i);
    int a, b, c, d;
    a = int'(pa[i*8 +: 8]);
    b = int'(pb[i*8 +: 8]);
    c = int'(pc[i*8 +: 8]);
    d = int'(pd[i*8 +: 8]);
    if (x <= a) return 0;
    if (x < b)  return (255 * (x - a)) / (b - a);
    if (x <= c) return 255;
    if (x < d)  return (255 * (d - x)) / (d - c);
    return 0;
  endfunction

  function automatic int n_slopes(input int x);
    int k = 0;
    for (int i = 0; i < 6; i++) begin
      if ((x > int'(pa[i*8 +: 8]) && x < int'(pb[i*8 +: 8])) ||
          (x > int'(pc[i*8 +: 8]) && x < int'(pd[i*8 +: 8]))) k++;
    end
    return k;
  endfunction

  function automatic logic [W-1:0] esperado(input int x);
    logic [7:0] g [6];
    for (int i = 0; i < 6; i++) g[i] = 8'(grau(x, i));
    return {g[4] != 0, g[2] != 0, g[0] != 0, g[5], g[4], g[3], g[2], g[1], g[0]};
  endfunction

  function automatic logic [W-1:0] observado();
    return {Ativo_3, Ativo_2, Ativo_1, MF_03_LOW, MF_03_UP, MF_02_LOW, MF_02_UP,
            MF_01_LOW, MF_01_UP};
  endfunction

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    int l;
    if (rst) begin
      aborted += exp_q.size();
      exp_q.delete();
      lat_q.delete();
      busy_m   = 1'b0;
      last_pub = '0;
      check("rst_outputs", observado(), '0);
      check("rst_fim", fim, 1'b0);
    end else begin
      if (fim) begin
        fim_count++;
        last_fim_edge = cyc;
        if (exp_q.size() == 0) begin
          check("fim_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          last_lat = cyc - last_acc_edge;
          check("degrees", observado(), e);
          check("latency", last_lat, l);
          last_pub = e;
        end
        busy_m = 1'b0;
      end else begin
        check("hold", observado(), last_pub);
      end
      check("pronto", pronto, !busy_m);
      if (pronto && valido) begin
        exp_q.push_back(esperado(int'(entrada)));
        lat_q.push_back(7 + 16 * n_slopes(int'(entrada)));
        last_acc_edge = cyc + 1;
        acc_count++;
        busy_m = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic wait_fim(input int n0);
    for (int c = 0; c < 300 && fim_count == n0; c++) @(posedge clk);
    #1;
    if (fim_count == n0) check("timeout_fim", 0, 1);
  endtask

  task automatic run(input int x);
    int n0;
    @(posedge clk); #1;
    entrada = 8'(x);
    valido  = 1'b1;
    n0 = fim_count;
    @(posedge clk); #1;
    valido = 1'b0;
    wait_fim(n0);
  endtask

  initial begin
    int n0, f1;
    rst = 1'b1; valido = 1'b0; entrada = '0;
    last_pub = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pronto", pronto, 1'b1);
    check("reset_fim", fim, 1'b0);
    check("reset_state", estado, S_IDLE);
    rst = 1'b0;

    run(40);
    check("x40_mf01up", MF_01_UP, 255);
    check("x40_mf01low", MF_01_LOW, 255);
    check("x40_mf02up", MF_02_UP, 0);
    check("x40_mf03up", MF_03_UP, 0);
    check("x40_ativo", {Ativo_1, Ativo_2, Ativo_3}, 3'b100);
    check("x40_lat", last_lat, 7);

    run(80);
    check("x80_mf01up", MF_01_UP, 127);
    check("x80_mf01low", MF_01_LOW, 63);
    check("x80_mf02up", MF_02_UP, 127);
    check("x80_mf02low", MF_02_LOW, 63);
    check("x80_mf03", {MF_03_UP, MF_03_LOW}, 0);
    check("x80_ativo", {Ativo_1, Ativo_2, Ativo_3}, 3'b110);
    check("x80_lat", last_lat, 71);

    run(255);
    check("x255_mf03", {MF_03_UP, MF_03_LOW}, 16'hFFFF);
    check("x255_mf01up", MF_01_UP, 0);
    check("x255_ativo", {Ativo_1, Ativo_2, Ativo_3}, 3'b001);
    check("x255_lat", last_lat, 7);

    run(0);
    check("x0_all", observado(), '0);

    // valido held high while busy: only the latched sample counts
    @(posedge clk); #1;
    entrada = 8'd80; valido = 1'b1;
    n0 = fim_count;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (fim) break;
      entrada = 8'($urandom_range(0, 255));
    end
    check("busy_fim_seen", fim, 1'b1);
    check("busy_mf01up", MF_01_UP, 127);
    check("busy_mf02low", MF_02_LOW, 63);
    f1 = cyc;
    entrada = 8'd40;
    n0 = n0 + 1;
    @(posedge clk); #1;
    valido = 1'b0;
    wait_fim(n0);
    check("b2b_accept_edge", last_acc_edge, f1 + 1);
    check("b2b_mf01low", MF_01_LOW, 255);

    // reset during DIV of an 80 run
    @(posedge clk); #1;
    entrada = 8'd80; valido = 1'b1;
    n0 = fim_count;
    @(posedge clk); #1;
    valido = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_state", estado, S_DIV);
    rst = 1'b1;
    #1;
    check("rst_mid_outputs", observado(), '0);
    check("rst_mid_pronto", pronto, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    check("rst_no_fim", fim_count, n0);
    check("rst_idle_pronto", pronto, 1'b1);
    run(40);
    check("after_rst_mf01up", MF_01_UP, 255);
    check("after_rst_lat", last_lat, 7);

    // full sweep with random idle gaps, then random samples
    for (int x = 0; x < 256; x++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run(x);
    end
    for (int j = 0; j < 60; j++) run(int'($urandom_range(0, 255)));

    repeat (3) @(posedge clk);
    #1;
    check("fim_vs_accepts", fim_count, acc_count - aborted);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
